// File: rtl/instr_encode_loader.sv
// -----------------------------------------------------------------------------
// instr_encode_loader
//
// Packs RV32I instruction fields plus a full 32-bit immediate into one
// instruction word (the inverse of the core's immediate decoder), range-checks
// the immediate, and writes the resulting words into instruction memory at
// consecutive byte addresses. A burst is opened with a start pulse, accepts
// `count` field bundles over a valid/ready handshake and closes with a
// one-cycle done pulse.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               begin a burst (honoured only when idle)
//   base_addr, count    first byte address (word aligned) and burst length
//   in_valid/in_ready   field bundle handshake
//   in_fmt              0 OP-IMM,1 LOAD,2 STORE,3 BRANCH,4 JAL,5 LUI,6 AUIPC,7 illegal
//   in_rd/rs1/rs2       register fields
//   in_funct3, in_imm   funct3 and signed immediate
//   imem_we/addr/wdata  registered IMEM write port
//   busy, done          burst in progress / burst complete pulse
//   err, err_addr       sticky encode failure and first failing address
//   words_written       words written so far in this burst
// -----------------------------------------------------------------------------
module instr_encode_loader #(
  parameter int          ADDR_W   = 10,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Major opcode for each field format.
  function automatic logic [6:0] opcode_of(input logic [2:0] fmt);
    logic [6:0] op;
    case (fmt)
      3'd0:    op = 7'b0010011;
      3'd1:    op = 7'b0000011;
      3'd2:    op = 7'b0100011;
      3'd3:    op = 7'b1100011;
      3'd4:    op = 7'b1101111;
      3'd5:    op = 7'b0110111;
      3'd6:    op = 7'b0010111;
      default: op = 7'b0000000;
    endcase
    return op;
  endfunction

  // True when the immediate is representable in the format. A signed range
  // check reduces to "all bits above the field's sign bit equal the sign".
  function automatic logic imm_legal(input logic [2:0] fmt, input logic [31:0] imm);
    logic ok;
    case (fmt)
      3'd0, 3'd1, 3'd2: ok = (imm[31:11] == {21{imm[31]}});
      3'd3:             ok = (imm[31:12] == {20{imm[31]}}) && (imm[0] == 1'b0);
      3'd4:             ok = (imm[31:20] == {12{imm[31]}}) && (imm[0] == 1'b0);
      3'd5, 3'd6:       ok = (imm[11:0] == 12'h000);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Scatter the immediate and register fields into the RV32I word layout.
  function automatic logic [31:0] encode(input logic [2:0]  fmt,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  f3,
                                         input logic [31:0] imm);
    logic [6:0]  op;
    logic [31:0] w;
    op = opcode_of(fmt);
    case (fmt)
      3'd0, 3'd1: w = {imm[11:0], rs1, f3, rd, op};
      3'd2:       w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:       w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd4:       w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      3'd5, 3'd6: w = {imm[31:12], rd, op};
      default:    w = NOP_WORD;
    endcase
    return w;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;          // address of the next word slot
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              accept_s;
  logic              legal_s;
  logic [31:0]       enc_s;

  assign in_ready = (state_q == S_LOAD) && (remaining_q != {CNT_W{1'b0}});
  assign accept_s = in_valid && in_ready;
  assign legal_s  = imm_legal(in_fmt, in_imm);
  assign enc_s    = encode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm);

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    words_d     = words_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
          remaining_d = count;
          err_d       = 1'b0;
          err_addr_d  = {ADDR_W{1'b0}};
          words_d     = {CNT_W{1'b0}};
          if (count == {CNT_W{1'b0}}) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          we_d        = 1'b1;
          waddr_d     = addr_q;
          wdata_d     = legal_s ? enc_s : NOP_WORD;
          addr_d      = addr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
          remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
          words_d     = words_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!legal_s) begin
            err_d = 1'b1;
            if (!err_q) begin
              err_addr_d = addr_q;
            end else begin
              err_addr_d = err_addr_q;
            end
          end else begin
            err_d = err_q;
          end
        end else if (remaining_q == {CNT_W{1'b0}}) begin
          // Last word is on the write port this cycle; done follows it.
          state_d = S_FLUSH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_FLUSH);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      remaining_q <= {CNT_W{1'b0}};
      we_q        <= 1'b0;
      waddr_q     <= {ADDR_W{1'b0}};
      wdata_q     <= 32'h00000000;
      err_q       <= 1'b0;
      err_addr_q  <= {ADDR_W{1'b0}};
      words_q     <= {CNT_W{1'b0}};
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      words_q     <= words_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = waddr_q;
  assign imem_wdata    = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_addr      = err_addr_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encode_loader
//
// Self-checking bench for instr_encode_loader. Each accepted bundle pushes its
// expected (address, word) onto a scoreboard queue; a negedge monitor pops and
// compares on every IMEM write. Scenario tasks check reset state, encodings,
// immediate boundaries, illegal words, address wrap and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_instr_encode_loader;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  words_written;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  instr_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (imem_we === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (imem_addr !== mon_e.a || imem_wdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL imem_write got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one bundle (called at a negedge), wait for acceptance, record expectation.
  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                      input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
    int   k;
    exp_t t;
    in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    t.a = ea; t.d = ed;
    sb.push_back(t);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge showing the final write; checks done and burst status.
  task automatic wait_done(input int exp_words, input logic exp_err,
                           input logic [ADDR_W-1:0] exp_eaddr);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse done=%b busy=%b we=%b expected 1 1 0", done, busy, imem_we);
    end
    n_checks++;
    if (words_written !== exp_words[CNT_W-1:0] || err !== exp_err ||
        (exp_err && err_addr !== exp_eaddr)) begin
      n_fail++;
      $display("FAIL burst_status words=%0d err=%b err_addr=%h expected %0d %b %h",
               words_written, err, err_addr, exp_words, exp_err, exp_eaddr);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_end done=%b busy=%b expected 0 0", done, busy);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_fmt = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd0;
    #12;
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata, busy, done, err, err_addr, words_written, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state we=%b addr=%h data=%h busy=%b done=%b err=%b ea=%h ww=%0d rdy=%b expected all 0",
               imem_we, imem_addr, imem_wdata, busy, done, err, err_addr, words_written, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ready in_ready=%b busy=%b expected 0 0", in_ready, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_encodings();
    // Single OP-IMM word.
    do_start(10'h040, 8'd1);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_entry busy=%b in_ready=%b expected 1 1", busy, in_ready);
    end
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 10'h040, 32'h00500093);
    wait_done(1, 1'b0, 10'h000);
    // Back-to-back STORE/BRANCH/LUI/JAL, with a start pulse mid-burst that must be ignored.
    do_start(10'h080, 8'd4);
    start = 1'b1; base_addr = 10'h300; count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,          10'h080, 32'h0020A423);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC,   10'h084, 32'hFE000EE3);
    send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000,   10'h088, 32'h123452B7);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800,   10'h08C, 32'h001000EF);
    wait_done(4, 1'b0, 10'h000);
  endtask

  task automatic test_bounds();
    // Unaligned base is forced to a word boundary.
    do_start(10'h202, 8'd6);
    send(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2047,       10'h200, 32'h7FF00013);
    send(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFF800,   10'h204, 32'h80000013);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094,       10'h208, 32'h7E000FE3);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3,          10'h20C, 32'h00000013);
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0,          10'h210, 32'h00000013);
    send(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345001,   10'h214, 32'h00000013);
    wait_done(6, 1'b1, 10'h20C);
  endtask

  task automatic test_illegal();
    do_start(10'h010, 8'd3);
    n_checks++;
    if (err !== 1'b0 || words_written !== 8'd0) begin
      n_fail++;
      $display("FAIL start_clears err=%b words=%0d expected 0 0", err, words_written);
    end
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1,    10'h010, 32'h00100093);
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 10'h014, 32'h00000013);
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2,    10'h018, 32'h00200093);
    wait_done(3, 1'b1, 10'h014);
  endtask

  task automatic test_wrap_random_valid();
    int   sent, cyc, d0, k;
    logic v;
    exp_t t;
    do_start(10'h3FC, 8'd2);
    d0 = done_cnt;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared err=%b expected 0", err);
    end
    sent = 0; cyc = 0;
    while (sent < 2 && cyc < 200) begin
      v = 1'(($urandom_range(0, 1)));
      in_fmt = 3'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0;
      in_rd  = (sent == 0) ? 5'd3 : 5'd4;
      in_imm = (sent == 0) ? 32'd7 : 32'd8;
      in_valid = v;
      if (v && in_ready === 1'b1) begin
        t.a = (sent == 0) ? 10'h3FC : 10'h000;
        t.d = (sent == 0) ? 32'h00700193 : 32'h00800213;
        sb.push_back(t);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done !== 1'b1 || words_written !== 8'd2) begin
      n_fail++;
      $display("FAIL wrap_done done=%b words=%0d expected 1 2", done, words_written);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_single_done pulses=%0d pending=%0d expected 1 0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_reset_midburst();
    int d0;
    do_start(10'h100, 8'd3);
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 10'h100, 32'h00100093);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata, busy, done, err, err_addr, words_written, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL midburst_reset we=%b addr=%h data=%h busy=%b done=%b ww=%0d rdy=%b expected all 0",
               imem_we, imem_addr, imem_wdata, busy, done, words_written, in_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_done_after_abort pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
    do_start(10'h000, 8'd0);
    n_checks++;
    if (done !== 1'b1 || imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_done done=%b we=%b expected 1 0", done, imem_we);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || words_written !== 8'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL zero_count_end done=%b busy=%b words=%0d pending=%0d expected 0 0 0 0",
               done, busy, words_written, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_bounds();
    test_illegal();
    test_wrap_random_valid();
    test_reset_midburst();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
